// File: rtl/id_ex_stage_pkg.sv
// Shared defaults and decoded-control bundle layout for the ID/EX stage.
// The bundle fields are packed LSB-first; bits above CTRL_ALU_SRC are reserved.
package id_ex_stage_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int NREG_DEFAULT = 32;
  localparam int CTRL_W       = 16;

  localparam int CTRL_REGWRITE       = 0;
  localparam int CTRL_RESULT_SRC     = 1;
  localparam int RESULT_SRC_W        = 2;
  localparam int CTRL_MEMWRITE       = 3;
  localparam int CTRL_JUMP           = 4;
  localparam int CTRL_BRANCH         = 5;
  localparam int CTRL_ALU_CONTROL    = 6;
  localparam int ALU_CONTROL_W       = 4;
  localparam int CTRL_BRANCH_CONTROL = 10;
  localparam int BRANCH_CONTROL_W    = 3;
  localparam int CTRL_ALU_SRC        = 13;

endpackage

// File: rtl/id_ex_stage_regfile_mp.sv
// Multi-port-write register file with optional same-cycle write-to-read bypass.
// Register 0 is hardwired to zero; the highest-index port wins on a write conflict.
module regfile_mp
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int NREG   = NREG_DEFAULT,
  parameter int NWB    = 1,
  parameter int BYPASS = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NWB-1:0]              wb_en,
  input  logic [NWB*$clog2(NREG)-1:0] wb_rd,
  input  logic [NWB*XLEN-1:0]         wb_data,
  input  logic [$clog2(NREG)-1:0]     rs1,
  input  logic [$clog2(NREG)-1:0]     rs2,
  output logic [XLEN-1:0]             rs1_data,
  output logic [XLEN-1:0]             rs2_data
);

  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];

  always_comb begin
    regs_d = regs_q;
    for (int k = 0; k < NWB; k++) begin
      if (wb_en[k]) regs_d[wb_rd[k*AW +: AW]] = wb_data[k*XLEN +: XLEN];
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) regs_q <= '{default: '0};
    else       regs_q <= regs_d;
  end

  // Later ports override earlier ones so the bypass agrees with what gets stored.
  always_comb begin
    rs1_data = regs_q[rs1];
    rs2_data = regs_q[rs2];
    if (BYPASS != 0) begin
      for (int k = 0; k < NWB; k++) begin
        if (wb_en[k] && (wb_rd[k*AW +: AW] != '0)) begin
          if (wb_rd[k*AW +: AW] == rs1) rs1_data = wb_data[k*XLEN +: XLEN];
          if (wb_rd[k*AW +: AW] == rs2) rs2_data = wb_data[k*XLEN +: XLEN];
        end
      end
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode-side register read plus the ID/EX pipeline register.
// Flush beats stall beats load; register-file writes happen regardless of either.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int NREG     = NREG_DEFAULT,
  parameter int NWB      = 1,
  parameter int CTRL_W   = id_ex_stage_pkg::CTRL_W,
  parameter int BYPASS   = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic [31:0]                 instruction,
  input  logic [XLEN-1:0]             pc,
  input  logic [XLEN-1:0]             pc_plus_4,
  input  logic [XLEN-1:0]             imm_in,
  input  logic [CTRL_W-1:0]           ctrl_in,
  input  logic                        stall_d,
  input  logic                        flush_d,
  input  logic [NWB-1:0]              wb_en,
  input  logic [NWB*$clog2(NREG)-1:0] wb_rd,
  input  logic [NWB*XLEN-1:0]         wb_data,
  output logic [$clog2(NREG)-1:0]     rs1_d,
  output logic [$clog2(NREG)-1:0]     rs2_d,
  output logic                        ex_valid,
  output logic [XLEN-1:0]             ex_rs1_data,
  output logic [XLEN-1:0]             ex_rs2_data,
  output logic [XLEN-1:0]             ex_imm,
  output logic [XLEN-1:0]             ex_pc,
  output logic [XLEN-1:0]             ex_pc_plus_4,
  output logic [$clog2(NREG)-1:0]     ex_rd,
  output logic [$clog2(NREG)-1:0]     ex_rs1,
  output logic [$clog2(NREG)-1:0]     ex_rs2,
  output logic [CTRL_W-1:0]           ex_ctrl
);

  localparam int AW = $clog2(NREG);

  logic [AW-1:0]   rd_d;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic            unused_instr;

  assign rs1_d        = instruction[15 +: AW];
  assign rs2_d        = instruction[20 +: AW];
  assign rd_d         = instruction[7 +: AW];
  assign unused_instr = ^instruction;

  regfile_mp #(
    .XLEN   (XLEN),
    .NREG   (NREG),
    .NWB    (NWB),
    .BYPASS (BYPASS)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .wb_en    (wb_en),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .rs1      (rs1_d),
    .rs2      (rs2_d),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data)
  );

  logic              ex_valid_q, ex_valid_d;
  logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
  logic [XLEN-1:0]   ex_rs1_data_q, ex_rs1_data_d;
  logic [XLEN-1:0]   ex_rs2_data_q, ex_rs2_data_d;
  logic [XLEN-1:0]   ex_imm_q, ex_imm_d;
  logic [XLEN-1:0]   ex_pc_q, ex_pc_d;
  logic [XLEN-1:0]   ex_pc4_q, ex_pc4_d;
  logic [AW-1:0]     ex_rd_q, ex_rd_d;
  logic [AW-1:0]     ex_rs1_q, ex_rs1_d;
  logic [AW-1:0]     ex_rs2_q, ex_rs2_d;

  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_ctrl_d     = ex_ctrl_q;
    ex_rs1_data_d = ex_rs1_data_q;
    ex_rs2_data_d = ex_rs2_data_q;
    ex_imm_d      = ex_imm_q;
    ex_pc_d       = ex_pc_q;
    ex_pc4_d      = ex_pc4_q;
    ex_rd_d       = ex_rd_q;
    ex_rs1_d      = ex_rs1_q;
    ex_rs2_d      = ex_rs2_q;
    if (flush_d) begin
      ex_valid_d    = 1'b0;
      ex_ctrl_d     = '0;
      ex_rs1_data_d = '0;
      ex_rs2_data_d = '0;
      ex_imm_d      = '0;
      ex_pc_d       = '0;
      ex_pc4_d      = '0;
      ex_rd_d       = '0;
      ex_rs1_d      = '0;
      ex_rs2_d      = '0;
    end else if (!stall_d) begin
      ex_valid_d    = in_valid;
      ex_ctrl_d     = in_valid ? ctrl_in : '0;
      ex_rs1_data_d = rs1_data;
      ex_rs2_data_d = rs2_data;
      ex_imm_d      = imm_in;
      ex_pc_d       = pc;
      ex_pc4_d      = pc_plus_4;
      ex_rd_d       = rd_d;
      ex_rs1_d      = rs1_d;
      ex_rs2_d      = rs2_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_q    <= 1'b0;
      ex_ctrl_q     <= '0;
      ex_rs1_data_q <= '0;
      ex_rs2_data_q <= '0;
      ex_imm_q      <= '0;
      ex_pc_q       <= '0;
      ex_pc4_q      <= '0;
      ex_rd_q       <= '0;
      ex_rs1_q      <= '0;
      ex_rs2_q      <= '0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_ctrl_q     <= ex_ctrl_d;
      ex_rs1_data_q <= ex_rs1_data_d;
      ex_rs2_data_q <= ex_rs2_data_d;
      ex_imm_q      <= ex_imm_d;
      ex_pc_q       <= ex_pc_d;
      ex_pc4_q      <= ex_pc4_d;
      ex_rd_q       <= ex_rd_d;
      ex_rs1_q      <= ex_rs1_d;
      ex_rs2_q      <= ex_rs2_d;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_ctrl      = ex_ctrl_q;
  assign ex_rs1_data  = ex_rs1_data_q;
  assign ex_rs2_data  = ex_rs2_data_q;
  assign ex_imm       = ex_imm_q;
  assign ex_pc        = ex_pc_q;
  assign ex_pc_plus_4 = ex_pc4_q;
  assign ex_rd        = ex_rd_q;
  assign ex_rs1       = ex_rs1_q;
  assign ex_rs2       = ex_rs2_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench: dut_a is dual-writeback with bypass, dut_b single-writeback without.
// Both share the decode-side inputs; only the writeback buses differ.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] instruction, pc, pc_plus_4, imm_in;
  logic [15:0] ctrl_in;
  logic        stall_d, flush_d;

  logic [1:0]  wba_en;
  logic [9:0]  wba_rd;
  logic [63:0] wba_data;
  logic        wbb_en;
  logic [4:0]  wbb_rd;
  logic [31:0] wbb_data;

  logic [4:0]  a_rs1_d, a_rs2_d, a_ex_rd, a_ex_rs1, a_ex_rs2;
  logic        a_ex_valid;
  logic [31:0] a_ex_rs1_data, a_ex_rs2_data, a_ex_imm, a_ex_pc, a_ex_pc4;
  logic [15:0] a_ex_ctrl;
  logic [4:0]  b_rs1_d, b_rs2_d, b_ex_rd, b_ex_rs1, b_ex_rs2;
  logic        b_ex_valid;
  logic [31:0] b_ex_rs1_data, b_ex_rs2_data, b_ex_imm, b_ex_pc, b_ex_pc4;
  logic [15:0] b_ex_ctrl;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .NREG(32), .NWB(2), .CTRL_W(16), .BYPASS(1)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .instruction(instruction),
    .pc(pc), .pc_plus_4(pc_plus_4), .imm_in(imm_in), .ctrl_in(ctrl_in),
    .stall_d(stall_d), .flush_d(flush_d),
    .wb_en(wba_en), .wb_rd(wba_rd), .wb_data(wba_data),
    .rs1_d(a_rs1_d), .rs2_d(a_rs2_d), .ex_valid(a_ex_valid),
    .ex_rs1_data(a_ex_rs1_data), .ex_rs2_data(a_ex_rs2_data), .ex_imm(a_ex_imm),
    .ex_pc(a_ex_pc), .ex_pc_plus_4(a_ex_pc4), .ex_rd(a_ex_rd),
    .ex_rs1(a_ex_rs1), .ex_rs2(a_ex_rs2), .ex_ctrl(a_ex_ctrl)
  );

  id_ex_stage #(.XLEN(32), .NREG(32), .NWB(1), .CTRL_W(16), .BYPASS(0)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .instruction(instruction),
    .pc(pc), .pc_plus_4(pc_plus_4), .imm_in(imm_in), .ctrl_in(ctrl_in),
    .stall_d(stall_d), .flush_d(flush_d),
    .wb_en(wbb_en), .wb_rd(wbb_rd), .wb_data(wbb_data),
    .rs1_d(b_rs1_d), .rs2_d(b_rs2_d), .ex_valid(b_ex_valid),
    .ex_rs1_data(b_ex_rs1_data), .ex_rs2_data(b_ex_rs2_data), .ex_imm(b_ex_imm),
    .ex_pc(b_ex_pc), .ex_pc_plus_4(b_ex_pc4), .ex_rd(b_ex_rd),
    .ex_rs1(b_ex_rs1), .ex_rs2(b_ex_rs2), .ex_ctrl(b_ex_ctrl)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_instr(input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic [4:0] rd);
    return {7'b0, rs2, rs1, 3'b0, rd, 7'b0110011};
  endfunction

  // Port 0 goes to both DUTs; port 1 only exists on dut_a.
  task automatic set_wb(input logic en0, input logic [4:0] rd0, input logic [31:0] d0,
                        input logic en1, input logic [4:0] rd1, input logic [31:0] d1);
    wba_en   = {en1, en0};
    wba_rd   = {rd1, rd0};
    wba_data = {d1, d0};
    wbb_en   = en0;
    wbb_rd   = rd0;
    wbb_data = d0;
  endtask

  task automatic set_dec(input logic v, input logic [31:0] instr, input logic [15:0] ctrl,
                         input logic [31:0] p, input logic [31:0] imm);
    in_valid    = v;
    instruction = instr;
    ctrl_in     = ctrl;
    pc          = p;
    pc_plus_4   = p + 32'd4;
    imm_in      = imm;
  endtask

  initial begin
    reset   = 1'b1;
    stall_d = 1'b0;
    flush_d = 1'b0;
    set_wb(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    set_dec(1'b0, 32'h0, 16'h0, 32'h0, 32'h0);
    repeat (2) tick();
    check("reset_valid", {31'b0, a_ex_valid}, 32'h0);
    check("reset_pc", a_ex_pc, 32'h0);
    reset = 1'b0;

    // x0 write is discarded and never bypassed
    set_wb(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0);
    set_dec(1'b1, mk_instr(5'd0, 5'd0, 5'd9), 16'h1234, 32'h40, 32'h55);
    tick();
    check("x0_rs1_a", a_ex_rs1_data, 32'h0);
    check("x0_rs1_b", b_ex_rs1_data, 32'h0);
    check("load_valid", {31'b0, a_ex_valid}, 32'h1);
    check("load_ctrl", {16'b0, a_ex_ctrl}, 32'h1234);
    check("load_rd", {27'b0, a_ex_rd}, 32'd9);
    check("load_imm", a_ex_imm, 32'h55);
    check("load_pc4", a_ex_pc4, 32'h44);

    // same-cycle bypass vs pre-write value
    set_wb(1'b1, 5'd7, 32'h1234_5678, 1'b0, 5'd0, 32'h0);
    set_dec(1'b1, mk_instr(5'd7, 5'd2, 5'd1), 16'h0001, 32'h48, 32'h0);
    #1;
    check("rs1_d_comb", {27'b0, a_rs1_d}, 32'd7);
    check("rs2_d_comb", {27'b0, a_rs2_d}, 32'd2);
    tick();
    check("bypass_on", a_ex_rs1_data, 32'h1234_5678);
    check("bypass_off", b_ex_rs1_data, 32'h0);
    set_wb(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    check("stored_x7_b", b_ex_rs1_data, 32'h1234_5678);

    // dual write to x3: port 1 wins, both for bypass and for storage
    set_wb(1'b1, 5'd3, 32'hA, 1'b1, 5'd3, 32'hB);
    set_dec(1'b1, mk_instr(5'd0, 5'd3, 5'd4), 16'h0002, 32'h50, 32'h0);
    tick();
    check("dual_bypass", a_ex_rs2_data, 32'hB);
    set_wb(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    set_dec(1'b1, mk_instr(5'd3, 5'd0, 5'd4), 16'h0002, 32'h54, 32'h0);
    tick();
    check("dual_stored", a_ex_rs1_data, 32'hB);

    // stall holds everything, writes still land; flush overrides stall
    set_dec(1'b1, mk_instr(5'd7, 5'd0, 5'd6), 16'h00AA, 32'h100, 32'h7);
    tick();
    check("pre_stall_pc", a_ex_pc, 32'h100);
    stall_d = 1'b1;
    set_dec(1'b1, mk_instr(5'd2, 5'd0, 5'd8), 16'h5555, 32'h200, 32'h9);
    set_wb(1'b1, 5'd7, 32'h99, 1'b0, 5'd0, 32'h0);
    repeat (2) tick();
    check("stall_pc", a_ex_pc, 32'h100);
    check("stall_ctrl", {16'b0, a_ex_ctrl}, 32'hAA);
    check("stall_rs1_data", a_ex_rs1_data, 32'h1234_5678);
    check("stall_rs1", {27'b0, a_ex_rs1}, 32'd7);
    check("stall_imm_b", b_ex_imm, 32'h7);
    flush_d = 1'b1;
    set_wb(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    check("flush_valid", {31'b0, a_ex_valid}, 32'h0);
    check("flush_ctrl", {16'b0, a_ex_ctrl}, 32'h0);
    check("flush_pc", a_ex_pc, 32'h0);
    check("flush_rs1_data", a_ex_rs1_data, 32'h0);
    check("flush_rd", {27'b0, a_ex_rd}, 32'h0);
    flush_d = 1'b0;
    stall_d = 1'b0;
    set_dec(1'b1, mk_instr(5'd7, 5'd0, 5'd6), 16'h0003, 32'h104, 32'h0);
    tick();
    check("stall_write_a", a_ex_rs1_data, 32'h99);
    check("stall_write_b", b_ex_rs1_data, 32'h99);

    // bubble: control masked, other fields still load
    set_dec(1'b0, mk_instr(5'd0, 5'd0, 5'd0), 16'hFFFF, 32'h300, 32'h0);
    tick();
    check("bubble_valid", {31'b0, a_ex_valid}, 32'h0);
    check("bubble_ctrl", {16'b0, a_ex_ctrl}, 32'h0);
    check("bubble_pc", a_ex_pc, 32'h300);

    // asynchronous reset mid-stall and mid-write clears state immediately
    set_wb(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0);
    set_dec(1'b1, mk_instr(5'd5, 5'd0, 5'd1), 16'h0001, 32'h400, 32'h0);
    tick();
    set_wb(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    check("x5_stored_b", b_ex_rs1_data, 32'hDEAD_BEEF);
    set_wb(1'b1, 5'd5, 32'h77, 1'b0, 5'd0, 32'h0);
    stall_d = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check("async_valid", {31'b0, a_ex_valid}, 32'h0);
    check("async_rs1_data", a_ex_rs1_data, 32'h0);
    check("async_ctrl", {16'b0, a_ex_ctrl}, 32'h0);
    check("async_pc_b", b_ex_pc, 32'h0);
    tick();
    reset   = 1'b0;
    stall_d = 1'b0;
    set_wb(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    set_dec(1'b1, mk_instr(5'd5, 5'd0, 5'd2), 16'h0022, 32'h500, 32'h0);
    tick();
    check("post_reset_x5_a", a_ex_rs1_data, 32'h0);
    check("post_reset_x5_b", b_ex_rs1_data, 32'h0);
    check("post_reset_valid", {31'b0, a_ex_valid}, 32'h1);
    check("post_reset_ctrl", {16'b0, a_ex_ctrl}, 32'h22);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
